// File: rtl/raster_pkg.sv
// Shared types and default resolution for the span rasterizer.
package raster_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        MODE_POINT = 1'b0,
        MODE_RECT  = 1'b1
    } mode_t;

    localparam int H_RES_DEF = 320;
    localparam int V_RES_DEF = 240;

endpackage

// File: rtl/raster_clip.sv
// Clamps the far corner of a command to the screen and flags commands
// that cover no visible pixel. Purely combinational.
module raster_clip #(
    parameter int H_RES = 320,
    parameter int V_RES = 240,
    parameter int X_W   = 9,
    parameter int Y_W   = 9
) (
    input  logic [X_W-1:0] x0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y0,
    input  logic [Y_W-1:0] y1,
    output logic [X_W-1:0] cx1,
    output logic [Y_W-1:0] cy1,
    output logic           empty
);

    // One extra bit so the limit is representable even when H_RES == 2**X_W.
    localparam logic [X_W:0]   X_LIM = (X_W+1)'(H_RES);
    localparam logic [Y_W:0]   Y_LIM = (Y_W+1)'(V_RES);
    localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

    // Clamp far corner; empty when the origin is off-screen or corners are inverted.
    always_comb begin
        cx1   = (x1 > X_MAX) ? X_MAX : x1;
        cy1   = (y1 > Y_MAX) ? Y_MAX : y1;
        empty = ({1'b0, x0} >= X_LIM) || ({1'b0, y0} >= Y_LIM) ||
                (x0 > x1) || (y0 > y1);
    end

endmodule

// File: rtl/span_rasterizer.sv
// Turns point / filled-rectangle commands into a row-major stream of
// linear frame-buffer writes with backpressure.
//
// Handshakes: a command transfers on a cycle where cmd_valid && cmd_ready;
// a frame-buffer write completes on a cycle where fb_we && fb_ready, and
// until then fb_we, fb_addr and fb_data are held unchanged.
module span_rasterizer
    import raster_pkg::*;
#(
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF,
    parameter int X_W     = 9,
    parameter int Y_W     = 9,
    parameter int COLOR_W = 8,
    parameter int ADDR_W  = 17
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_mode,
    input  logic [X_W-1:0]     cmd_x0,
    input  logic [X_W-1:0]     cmd_x1,
    input  logic [Y_W-1:0]     cmd_y0,
    input  logic [Y_W-1:0]     cmd_y1,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    output logic               fb_we,
    input  logic               fb_ready,
    output logic               done,
    output logic [1:0]         fsm_state
);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

    state_t state, state_next;

    logic [X_W-1:0]     x0_q, x1_q, cx1_q, x;
    logic [Y_W-1:0]     y0_q, y1_q, cy1_q, y;
    logic [COLOR_W-1:0] color_q;
    logic [ADDR_W-1:0]  row_base;
    logic [ADDR_W-1:0]  base0;

    logic [X_W-1:0] clip_x1;
    logic [Y_W-1:0] clip_y1;
    logic           empty;
    logic           accept;
    logic           advance;
    logic           last_pixel;

    raster_clip #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .X_W   (X_W),
        .Y_W   (Y_W)
    ) u_clip (
        .x0    (x0_q),
        .x1    (x1_q),
        .y0    (y0_q),
        .y1    (y1_q),
        .cx1   (clip_x1),
        .cy1   (clip_y1),
        .empty (empty)
    );

    assign cmd_ready  = (state == IDLE) && !reset;
    assign accept     = cmd_valid && cmd_ready;
    assign advance    = (state == FILL) && fb_we && fb_ready;
    assign last_pixel = (x == cx1_q) && (y == cy1_q);
    // The only multiply; evaluated once per command in SETUP.
    assign base0      = ADDR_W'(y0_q) * ROW_STEP;
    assign fsm_state  = state;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   state_next = empty ? DONE : FILL;
            FILL:    if (advance && last_pixel) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command latch, pixel counters and registered write-port outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0_q     <= '0;
            x1_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            cx1_q    <= '0;
            cy1_q    <= '0;
            color_q  <= '0;
            x        <= '0;
            y        <= '0;
            row_base <= '0;
            fb_addr  <= '0;
            fb_data  <= '0;
            fb_we    <= 1'b0;
            done     <= 1'b0;
        end else begin
            // DONE is only ever entered for one cycle, so this is a single pulse.
            done <= (state_next == DONE);
            if (state == IDLE && accept) begin
                x0_q    <= cmd_x0;
                y0_q    <= cmd_y0;
                x1_q    <= (cmd_mode == MODE_RECT) ? cmd_x1 : cmd_x0;
                y1_q    <= (cmd_mode == MODE_RECT) ? cmd_y1 : cmd_y0;
                color_q <= cmd_color;
            end
            if (state == SETUP && !empty) begin
                x        <= x0_q;
                y        <= y0_q;
                row_base <= base0;
                cx1_q    <= clip_x1;
                cy1_q    <= clip_y1;
                fb_we    <= 1'b1;
                fb_addr  <= base0 + ADDR_W'(x0_q);
                fb_data  <= color_q;
            end
            if (advance) begin
                if (last_pixel) begin
                    fb_we <= 1'b0;
                end else if (x < cx1_q) begin
                    x       <= x + 1'b1;
                    fb_addr <= row_base + ADDR_W'(x + 1'b1);
                end else begin
                    x        <= x0_q;
                    y        <= y + 1'b1;
                    row_base <= row_base + ROW_STEP;
                    fb_addr  <= row_base + ROW_STEP + ADDR_W'(x0_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_span_rasterizer.sv
// Self-checking bench for span_rasterizer: scenario tasks plus a write
// monitor that pops expected {addr,data} pairs from a queue.
module tb_span_rasterizer;
    import raster_pkg::*;

    localparam int H_RES   = 320;
    localparam int V_RES   = 240;
    localparam int X_W     = 9;
    localparam int Y_W     = 9;
    localparam int COLOR_W = 8;
    localparam int ADDR_W  = 17;
    localparam int SB_W    = ADDR_W + COLOR_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_mode;
    logic [X_W-1:0]     cmd_x0, cmd_x1;
    logic [Y_W-1:0]     cmd_y0, cmd_y1;
    logic [COLOR_W-1:0] cmd_color;
    logic [ADDR_W-1:0]  fb_addr;
    logic [COLOR_W-1:0] fb_data;
    logic               fb_we;
    logic               fb_ready;
    logic               done;
    logic [1:0]         fsm_state;

    span_rasterizer #(
        .H_RES(H_RES), .V_RES(V_RES), .X_W(X_W), .Y_W(Y_W),
        .COLOR_W(COLOR_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_x0(cmd_x0), .cmd_x1(cmd_x1),
        .cmd_y0(cmd_y0), .cmd_y1(cmd_y1), .cmd_color(cmd_color),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
        .fb_ready(fb_ready), .done(done), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [SB_W-1:0]    exp_q[$];
    logic [SB_W-1:0]    exp_item;
    int n_checks = 0;
    int n_fail   = 0;
    int n_writes, n_we_cycles, n_done;
    int first_we_cyc, last_write_cyc, done_cyc;
    logic               prev_stall = 1'b0;
    logic [ADDR_W-1:0]  prev_addr;
    logic [COLOR_W-1:0] prev_data;
    bit                 rand_ready = 1'b0;

    // Write monitor: samples on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                if (fb_we !== 1'b1 || fb_addr !== prev_addr || fb_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: we=%b addr=%0d data=%h, required we=1 addr=%0d data=%h",
                             fb_we, fb_addr, fb_data, prev_addr, prev_data);
                end
            end
            if (fb_we === 1'b1) begin
                n_we_cycles++;
                if (first_we_cyc < 0) first_we_cyc = cyc;
                if (fb_ready) begin
                    n_writes++;
                    last_write_cyc = cyc;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_write: addr=%0d data=%h, required no write",
                                 fb_addr, fb_data);
                    end else begin
                        exp_item = exp_q.pop_front();
                        if ({fb_addr, fb_data} !== exp_item) begin
                            n_fail++;
                            $display("FAIL write_data: addr=%0d data=%h, required addr=%0d data=%h",
                                     fb_addr, fb_data, exp_item[SB_W-1:COLOR_W], exp_item[COLOR_W-1:0]);
                        end
                    end
                end
            end
            if (done === 1'b1) begin
                n_done++;
                done_cyc = cyc;
            end
            prev_stall = (fb_we === 1'b1) && (fb_ready === 1'b0);
            prev_addr  = fb_addr;
            prev_data  = fb_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
        if (rand_ready) fb_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic clear_counters;
        n_writes       = 0;
        n_we_cycles    = 0;
        n_done         = 0;
        first_we_cyc   = -1;
        last_write_cyc = -1;
        done_cyc       = -1;
    endtask

    task automatic drive_cmd(input logic mode, input int x0, input int y0,
                             input int x1, input int y1, input int color);
        cmd_mode  = mode;
        cmd_x0    = X_W'(x0);
        cmd_y0    = Y_W'(y0);
        cmd_x1    = X_W'(x1);
        cmd_y1    = Y_W'(y1);
        cmd_color = COLOR_W'(color);
    endtask

    // Expected writes for a command, computed from the clipped bounds.
    task automatic push_model(input int x0, input int y0, input int x1, input int y1,
                              input int color, output int n);
        int xe, ye;
        xe = (x1 > H_RES - 1) ? H_RES - 1 : x1;
        ye = (y1 > V_RES - 1) ? V_RES - 1 : y1;
        n  = 0;
        for (int yy = y0; yy <= ye; yy++) begin
            for (int xx = x0; xx <= xe; xx++) begin
                exp_q.push_back({ADDR_W'(yy * H_RES + xx), COLOR_W'(color)});
                n++;
            end
        end
    endtask

    // Waits for cmd_ready, presents one command for a single accepting cycle.
    task automatic send_cmd(input logic mode, input int x0, input int y0,
                            input int x1, input int y1, input int color, output int c);
        int k;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 2000) begin
            tick();
            k++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_timeout: cmd_ready=%b, required 1", cmd_ready);
        end
        drive_cmd(mode, x0, y0, x1, y1, color);
        cmd_valid = 1'b1;
        c = cyc;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            tick();
            k++;
        end
        n_checks++;
        if (n_done < target) begin
            n_fail++;
            $display("FAIL done_timeout: done count=%0d, required %0d", n_done, target);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b1;
        cmd_valid = 1'b0;
        fb_ready = 1'b1;
        drive_cmd(1'b0, 0, 0, 0, 0, 0);
        tick();
        tick();
        n_checks++;
        if ({cmd_ready, fb_we, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready/we/done=%b, required 000", {cmd_ready, fb_we, done});
        end
        n_checks++;
        if (fb_addr !== '0 || fb_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%0d data=%h, required 0 0", fb_addr, fb_data);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: cmd_ready=%b, required 1", cmd_ready);
        end
    endtask

    task automatic test_point;
        int c, n;
        clear_counters();
        push_model(5, 2, 5, 2, 'hA5, n);
        // Corner fields deliberately nonsense: point mode must ignore them.
        send_cmd(MODE_POINT, 5, 2, 100, 100, 'hA5, c);
        wait_done(1, 50);
        n_checks++;
        if (first_we_cyc !== c + 2) begin
            n_fail++;
            $display("FAIL point_first_we: cycle=%0d, required %0d", first_we_cyc, c + 2);
        end
        n_checks++;
        if (n_we_cycles !== 1 || n_writes !== 1) begin
            n_fail++;
            $display("FAIL point_we_count: we cycles=%0d writes=%0d, required 1 1", n_we_cycles, n_writes);
        end
        n_checks++;
        if (done_cyc !== c + 3) begin
            n_fail++;
            $display("FAIL point_done: cycle=%0d, required %0d", done_cyc, c + 3);
        end
        n_checks++;
        if (cmd_ready !== 1'b1 || cyc !== c + 4) begin
            n_fail++;
            $display("FAIL point_ready: ready=%b at cycle %0d, required 1 at %0d", cmd_ready, cyc, c + 4);
        end
    endtask

    task automatic test_clip;
        int c;
        clear_counters();
        exp_q.push_back({17'd76478, 8'h3C});
        exp_q.push_back({17'd76479, 8'h3C});
        exp_q.push_back({17'd76798, 8'h3C});
        exp_q.push_back({17'd76799, 8'h3C});
        send_cmd(MODE_RECT, 318, 238, 400, 300, 'h3C, c);
        wait_done(1, 50);
        n_checks++;
        if (n_writes !== 4 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL clip_count: writes=%0d left=%0d, required 4 0", n_writes, exp_q.size());
        end
        n_checks++;
        if (first_we_cyc !== c + 2 || done_cyc !== c + 6 || done_cyc !== last_write_cyc + 1) begin
            n_fail++;
            $display("FAIL clip_timing: first=%0d last=%0d done=%0d, required %0d %0d %0d",
                     first_we_cyc, last_write_cyc, done_cyc, c + 2, c + 5, c + 6);
        end
    endtask

    task automatic test_backpressure;
        int c, n;
        clear_counters();
        push_model(0, 0, 3, 1, 'h5A, n);
        send_cmd(MODE_RECT, 0, 0, 3, 1, 'h5A, c);
        repeat (3) tick();              // now in cycle C+4: third write on the port
        fb_ready = 1'b0;
        repeat (3) tick();
        fb_ready = 1'b1;
        wait_done(1, 50);
        n_checks++;
        if (n_writes !== 8 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL bp_count: writes=%0d left=%0d, required 8 0", n_writes, exp_q.size());
        end
        n_checks++;
        if (n_we_cycles !== 11 || done_cyc !== c + 13) begin
            n_fail++;
            $display("FAIL bp_timing: we cycles=%0d done=%0d, required 11 %0d", n_we_cycles, done_cyc, c + 13);
        end
    endtask

    task automatic test_empty;
        int c;
        for (int i = 0; i < 2; i++) begin
            clear_counters();
            if (i == 0) send_cmd(MODE_RECT, 10, 4, 5, 4, 'h77, c);
            else        send_cmd(MODE_POINT, 320, 4, 0, 0, 'h77, c);
            wait_done(1, 20);
            n_checks++;
            if (n_we_cycles !== 0 || done_cyc !== c + 2) begin
                n_fail++;
                $display("FAIL empty_%0d: we cycles=%0d done=%0d, required 0 %0d", i, n_we_cycles, done_cyc, c + 2);
            end
            n_checks++;
            if (cmd_ready !== 1'b1 || cyc !== c + 3) begin
                n_fail++;
                $display("FAIL empty_ready_%0d: ready=%b at %0d, required 1 at %0d", i, cmd_ready, cyc, c + 3);
            end
        end
    endtask

    task automatic test_reset_mid_fill;
        int c, n;
        clear_counters();
        for (int a = 0; a < 10; a++) exp_q.push_back({ADDR_W'(a), 8'hC3});
        send_cmd(MODE_RECT, 0, 0, 319, 239, 'hC3, c);
        repeat (11) tick();             // writes of cycles C+2..C+11 observed
        reset = 1'b1;
        #1;
        n_checks++;
        if (fb_we !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: we=%b done=%b ready=%b, required 0 0 0", fb_we, done, cmd_ready);
        end
        n_checks++;
        if (n_writes !== 10 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL midreset_prefix: writes=%0d left=%0d, required 10 0", n_writes, exp_q.size());
        end
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_ready: cmd_ready=%b, required 1", cmd_ready);
        end
        clear_counters();
        push_model(0, 0, 0, 0, 'h99, n);
        send_cmd(MODE_POINT, 0, 0, 0, 0, 'h99, c);
        wait_done(1, 50);
        n_checks++;
        if (n_writes !== 1 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL midreset_point: writes=%0d left=%0d, required 1 0", n_writes, exp_q.size());
        end
    endtask

    task automatic test_hold_valid;
        int c, c2, k, n;
        clear_counters();
        push_model(0, 0, 2, 0, 'h11, n);
        push_model(7, 1, 7, 1, 'h22, n);
        drive_cmd(MODE_RECT, 0, 0, 2, 0, 'h11);
        cmd_valid = 1'b1;
        c = cyc;
        tick();
        drive_cmd(MODE_POINT, 7, 1, 0, 0, 'h22);
        k = 0;
        while (cmd_ready !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        c2 = cyc;
        n_checks++;
        if (c2 !== c + 6) begin
            n_fail++;
            $display("FAIL hold_accept: second accepted at %0d, required %0d", c2, c + 6);
        end
        tick();
        cmd_valid = 1'b0;
        wait_done(2, 50);
        repeat (3) tick();
        n_checks++;
        if (n_writes !== 4 || exp_q.size() !== 0 || n_done !== 2) begin
            n_fail++;
            $display("FAIL hold_exec: writes=%0d left=%0d dones=%0d, required 4 0 2",
                     n_writes, exp_q.size(), n_done);
        end
    endtask

    task automatic test_back_to_back;
        int c, n, x0, x1, y0, y1, col;
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            x0  = $urandom_range(300, 325);
            x1  = x0 + $urandom_range(0, 7) - 2;
            y0  = $urandom_range(232, 244);
            y1  = y0 + $urandom_range(0, 5) - 1;
            col = $urandom_range(0, 255);
            clear_counters();
            push_model(x0, y0, x1, y1, col, n);
            send_cmd(MODE_RECT, x0, y0, x1, y1, col, c);
            wait_done(1, 500);
            n_checks++;
            if (n_writes !== n || exp_q.size() !== 0) begin
                n_fail++;
                $display("FAIL b2b_%0d: writes=%0d left=%0d, required %0d 0", i, n_writes, exp_q.size(), n);
            end
        end
        rand_ready = 1'b0;
        fb_ready = 1'b1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        clear_counters();
        test_reset();
        test_point();
        test_clip();
        test_backpressure();
        test_empty();
        test_reset_mid_fill();
        test_hold_valid();
        test_back_to_back();
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
